// File: rtl/decrypt_frame_loader.sv
// Byte-serial receiver assembling 78-bit ciphertext frames for decrypt_function_4, double-buffered.
// Optional trailing XOR checksum byte enabled by defining DEC_FRAME_CHECKSUM_EN.
module decrypt_frame_loader #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_sof,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [0:77] data_1,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_count
);

`ifdef DEC_FRAME_CHECKSUM_EN
    localparam logic [3:0] LAST = 4'd10;
`else
    localparam logic [3:0] LAST = 4'd9;
`endif

    localparam logic ST_COLLECT = 1'b0;
    localparam logic ST_HOLD    = 1'b1;

    localparam logic [1:0] ERR_PAD     = 2'd0;
    localparam logic [1:0] ERR_RESYNC  = 2'd1;
    localparam logic [1:0] ERR_NOSOF   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    logic        state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] idle_q, idle_d;
    logic [0:77] asm_q, asm_d;
    logic [0:77] data_q, data_d;
    logic        fv_q, fv_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic [15:0] cnt_q, cnt_d;
`ifdef DEC_FRAME_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
    logic [1:0]  pad_q, pad_d;
`endif

    logic acc;
    logic drain;
    logic frame_ok;

    assign byte_ready  = (state_q == ST_COLLECT);
    assign data_1      = data_q;
    assign frame_valid = fv_q;
    assign frame_err   = err_q;
    assign err_code    = code_q;
    assign frame_count = cnt_q;

    always_comb begin
        acc      = byte_valid && byte_ready;
        drain    = fv_q && frame_ready;
        frame_ok = 1'b0;
        state_d  = state_q;
        idx_d    = idx_q;
        idle_d   = idle_q;
        asm_d    = asm_q;
        data_d   = data_q;
        fv_d     = fv_q;
        err_d    = 1'b0;
        code_d   = code_q;
        cnt_d    = cnt_q;
`ifdef DEC_FRAME_CHECKSUM_EN
        csum_d   = csum_q;
        pad_d    = pad_q;
`endif

        if (drain) begin
            fv_d  = 1'b0;
            cnt_d = cnt_q + 16'd1;
        end

        if (state_q == ST_HOLD) begin
            // The held frame moves into the output register in the same cycle the old one drains.
            if (drain) begin
                data_d  = asm_q;
                fv_d    = 1'b1;
                state_d = ST_COLLECT;
            end
        end else if (acc) begin
            idle_d = '0;
            if (byte_sof) begin
                asm_d[0:7] = byte_in;
                idx_d      = 4'd1;
`ifdef DEC_FRAME_CHECKSUM_EN
                csum_d     = byte_in;
`endif
                if (idx_q != '0) begin
                    err_d  = 1'b1;
                    code_d = ERR_RESYNC;
                end
            end else if (idx_q == '0) begin
                err_d  = 1'b1;
                code_d = ERR_NOSOF;
            end else begin
                for (int unsigned k = 1; k < 9; k++) begin
                    if (idx_q == 4'(k)) asm_d[8*k +: 8] = byte_in;
                end
                if (idx_q == 4'd9) begin
                    asm_d[72:77] = byte_in[7:2];
`ifdef DEC_FRAME_CHECKSUM_EN
                    pad_d        = byte_in[1:0];
`endif
                end
`ifdef DEC_FRAME_CHECKSUM_EN
                if (idx_q <= 4'd9) csum_d = csum_q ^ byte_in;
`endif
                if (idx_q == LAST) begin
                    idx_d = '0;
`ifdef DEC_FRAME_CHECKSUM_EN
                    frame_ok = (pad_q == 2'b00) && (csum_q == byte_in);
`else
                    frame_ok = (byte_in[1:0] == 2'b00);
`endif
                    if (!frame_ok) begin
                        err_d  = 1'b1;
                        code_d = ERR_PAD;
                    end else if (!fv_q || drain) begin
                        data_d = asm_d;
                        fv_d   = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
        end else if (idx_q != '0) begin
            if ((32'(idle_q) + 32'd1) >= 32'(TIMEOUT)) begin
                idle_d = '0;
                idx_d  = '0;
                err_d  = 1'b1;
                code_d = ERR_TIMEOUT;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_COLLECT;
            idx_q   <= '0;
            idle_q  <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
`ifdef DEC_FRAME_CHECKSUM_EN
            csum_q  <= '0;
            pad_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            fv_q    <= fv_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
`ifdef DEC_FRAME_CHECKSUM_EN
            csum_q  <= csum_d;
            pad_q   <= pad_d;
`endif
        end
    end

endmodule

// File: tb/tb_decrypt_frame_loader.sv
// Directed self-checking bench for decrypt_frame_loader (TIMEOUT overridden to 4).
module tb_decrypt_frame_loader;

    logic        Clk;
    logic        Rst_n;
    logic [7:0]  byte_in;
    logic        byte_sof;
    logic        byte_valid;
    logic        byte_ready;
    logic [0:77] data_1;
    logic        frame_valid;
    logic        frame_ready;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  fb [10];
    logic [0:77] exp_a;
    logic [0:77] exp_b;

    decrypt_frame_loader #(.TIMEOUT(4)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .byte_in    (byte_in),
        .byte_sof   (byte_sof),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .data_1     (data_1),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .frame_count(frame_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic sof);
        byte_in    = b;
        byte_sof   = sof;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
        byte_sof   = 1'b0;
    endtask

    task automatic send_bytes(input int from, input bit bad_cs);
        logic [7:0] cs;
        for (int i = from; i < 10; i++) send_byte(fb[i], i == 0);
`ifdef DEC_FRAME_CHECKSUM_EN
        cs = 8'h00;
        for (int i = 0; i < 10; i++) cs = cs ^ fb[i];
        if (bad_cs) cs = cs ^ 8'h01;
        send_byte(cs, 1'b0);
`else
        if (bad_cs) send_byte(8'h00, 1'b0);
`endif
    endtask

    function automatic logic [0:77] mk_exp();
        logic [7:0] last;
        last = fb[9];
        return {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5], fb[6], fb[7], fb[8], last[7:2]};
    endfunction

    initial begin
        Rst_n       = 1'b0;
        byte_in     = 8'h00;
        byte_sof    = 1'b0;
        byte_valid  = 1'b0;
        frame_ready = 1'b1;
        #12;
        chk("reset_data", 78'(data_1), 78'd0);
        chk("reset_fv", 78'(frame_valid), 78'd0);
        chk("reset_err", 78'(frame_err), 78'd0);
        chk("reset_code", 78'(err_code), 78'd0);
        chk("reset_count", 78'(frame_count), 78'd0);
        chk("reset_ready", 78'(byte_ready), 78'd1);
        Rst_n = 1'b1;
        step();

        // Single frame 00..08, FC
        for (int i = 0; i < 9; i++) fb[i] = 8'(i);
        fb[9] = 8'hFC;
        exp_a = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 6'b111111};
        send_bytes(0, 1'b0);
        chk("single_fv", 78'(frame_valid), 78'd1);
        chk("single_data", 78'(data_1), 78'(exp_a));
        chk("single_err", 78'(frame_err), 78'd0);
        step();
        chk("single_drained", 78'(frame_valid), 78'd0);
        chk("single_count", 78'(frame_count), 78'd1);

        // Pad error, then a good frame
        for (int i = 0; i < 9; i++) fb[i] = 8'h10 + 8'(i);
        fb[9] = 8'hFD;
        send_bytes(0, 1'b0);
        chk("pad_err", 78'(frame_err), 78'd1);
        chk("pad_code", 78'(err_code), 78'd0);
        chk("pad_nofv", 78'(frame_valid), 78'd0);
        step();
        chk("pad_pulse_end", 78'(frame_err), 78'd0);
        for (int i = 0; i < 9; i++) fb[i] = 8'hA0 + 8'(i);
        fb[9] = 8'h54;
        exp_a = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 6'h15};
        send_bytes(0, 1'b0);
        chk("after_pad_fv", 78'(frame_valid), 78'd1);
        chk("after_pad_data", 78'(data_1), 78'(exp_a));
        step();
        chk("after_pad_count", 78'(frame_count), 78'd2);

        // Resync: SOF arrives as the 5th byte of a partial frame
        send_byte(8'h55, 1'b1);
        for (int i = 1; i < 4; i++) send_byte(8'h55, 1'b0);
        for (int i = 0; i < 9; i++) fb[i] = 8'h30 + 8'(i);
        fb[9] = 8'h40;
        send_byte(fb[0], 1'b1);
        chk("resync_err", 78'(frame_err), 78'd1);
        chk("resync_code", 78'(err_code), 78'd1);
        send_bytes(1, 1'b0);
        chk("resync_fv", 78'(frame_valid), 78'd1);
        chk("resync_data", 78'(data_1), 78'(mk_exp()));
        step();
        chk("resync_count", 78'(frame_count), 78'd3);

        // Timeout after byte 3, then a stray non-SOF byte
        send_byte(8'h77, 1'b1);
        for (int i = 1; i < 4; i++) send_byte(8'h77, 1'b0);
        step();
        step();
        step();
        chk("timeout_early", 78'(frame_err), 78'd0);
        step();
        chk("timeout_err", 78'(frame_err), 78'd1);
        chk("timeout_code", 78'(err_code), 78'd3);
        send_byte(8'h12, 1'b0);
        chk("nosof_err", 78'(frame_err), 78'd1);
        chk("nosof_code", 78'(err_code), 78'd2);
        step();
        chk("nosof_nofv", 78'(frame_valid), 78'd0);

        // Backpressure: A held in output register, B waits in HOLD
        frame_ready = 1'b0;
        for (int i = 0; i < 9; i++) fb[i] = 8'(8'h11 * i);
        fb[9] = 8'h88;
        exp_a = mk_exp();
        send_bytes(0, 1'b0);
        chk("bp_a_fv", 78'(frame_valid), 78'd1);
        chk("bp_a_data", 78'(data_1), 78'(exp_a));
        for (int i = 0; i < 9; i++) fb[i] = 8'hF0 - 8'(i);
        fb[9] = 8'h24;
        exp_b = mk_exp();
        send_bytes(0, 1'b0);
        chk("bp_hold_ready", 78'(byte_ready), 78'd0);
        chk("bp_hold_data", 78'(data_1), 78'(exp_a));
        step();
        step();
        chk("bp_still_ready", 78'(byte_ready), 78'd0);
        chk("bp_still_data", 78'(data_1), 78'(exp_a));
        chk("bp_still_count", 78'(frame_count), 78'd3);
        frame_ready = 1'b1;
        step();
        chk("bp_b_fv", 78'(frame_valid), 78'd1);
        chk("bp_b_data", 78'(data_1), 78'(exp_b));
        chk("bp_b_ready", 78'(byte_ready), 78'd1);
        chk("bp_a_count", 78'(frame_count), 78'd4);
        step();
        chk("bp_b_drained", 78'(frame_valid), 78'd0);
        chk("bp_b_count", 78'(frame_count), 78'd5);

        // Mid-frame asynchronous reset
        send_byte(8'hC3, 1'b1);
        send_byte(8'hC4, 1'b0);
        send_byte(8'hC5, 1'b0);
        Rst_n = 1'b0;
        #1;
        chk("mrst_data", 78'(data_1), 78'd0);
        chk("mrst_fv", 78'(frame_valid), 78'd0);
        chk("mrst_err", 78'(frame_err), 78'd0);
        chk("mrst_code", 78'(err_code), 78'd0);
        chk("mrst_count", 78'(frame_count), 78'd0);
        chk("mrst_ready", 78'(byte_ready), 78'd1);
        #2;
        Rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) fb[i] = 8'h5A ^ 8'(i);
        fb[9] = 8'hB8;
`ifdef DEC_FRAME_CHECKSUM_EN
        send_bytes(0, 1'b1);
        chk("cs_bad_err", 78'(frame_err), 78'd1);
        chk("cs_bad_code", 78'(err_code), 78'd0);
        chk("cs_bad_nofv", 78'(frame_valid), 78'd0);
`endif
        send_bytes(0, 1'b0);
        chk("post_rst_fv", 78'(frame_valid), 78'd1);
        chk("post_rst_data", 78'(data_1), 78'(mk_exp()));
        step();
        chk("post_rst_count", 78'(frame_count), 78'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
